// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
//  Module   : half_adder
//  Purpose  : WIDTH independent 1-bit half adders. Each lane has a
//             combinational sum/carry and a one-stage registered copy
//             qualified by a valid flag.
//  Option   : HALF_ADDER_CNT_EN adds carry_cnt, a wrapping count of carry
//             events captured on valid cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
`ifdef HALF_ADDER_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  // Reject illegal configurations when the design is elaborated.
  if (WIDTH < 1) begin : g_width_chk
    $error("half_adder: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("half_adder: CNT_W must be at least 1");
  end

  // Lanes are fully independent: no carry ripples from one lane to the next.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign sum[i]   = a[i] ^ b[i];
    assign carry[i] = a[i] & b[i];
  end

  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;

  // Capture a fresh result on valid input; otherwise hold data, drop valid.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = sum;
      carry_d     = carry;
      out_valid_d = 1'b1;
    end
  end

  // Registered result; reset clears it immediately, without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= '0;
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef HALF_ADDER_CNT_EN
  logic [CNT_W-1:0] carry_cnt_d;

  // Add the number of carrying lanes on every valid cycle; wraps silently.
  always_comb begin
    carry_cnt_d = carry_cnt;
    if (in_valid) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (carry[i]) begin
          carry_cnt_d = carry_cnt_d + CNT_W'(1);
        end
      end
    end
  end

  // Carry-event counter register, cleared asynchronously with the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt <= '0;
    end else begin
      carry_cnt <= carry_cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_half_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_half_adder
//  Purpose  : Self-checking bench for half_adder (WIDTH=4, CNT_W=4).
//             Counter checks are included when HALF_ADDER_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_half_adder;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic             out_valid;
`ifdef HALF_ADDER_CNT_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state for the registered path.
  logic [WIDTH-1:0] m_sum_q;
  logic [WIDTH-1:0] m_carry_q;
  logic             m_valid;
  int               m_cnt;

  half_adder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .sum_q     (sum_q),
    .carry_q   (carry_q),
    .out_valid (out_valid)
`ifdef HALF_ADDER_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Lane-wise arithmetic: a lane's two-bit total is a+b; sum is its LSB value.
  function automatic logic [WIDTH-1:0] ref_sum(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int t;
      t = int'(x[i]) + int'(y[i]);
      r[i] = (t % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] ref_carry(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      int t;
      t = int'(x[i]) + int'(y[i]);
      r[i] = (t / 2) == 1;
    end
    return r;
  endfunction

  function automatic int n_carries(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) begin
      n += (int'(x[i]) + int'(y[i])) / 2;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    chk({tag, ".sum"},   32'(sum),   32'(ref_sum(a, b)));
    chk({tag, ".carry"}, 32'(carry), 32'(ref_carry(a, b)));
  endtask

  task automatic chk_reg(input string tag);
    chk({tag, ".sum_q"},     32'(sum_q),     32'(m_sum_q));
    chk({tag, ".carry_q"},   32'(carry_q),   32'(m_carry_q));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
`ifdef HALF_ADDER_CNT_EN
    chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic model_reset();
    m_sum_q   = '0;
    m_carry_q = '0;
    m_valid   = 1'b0;
    m_cnt     = 0;
  endtask

  // One clock: drive at negedge, check comb, advance model at posedge, check regs.
  task automatic cycle(input string tag, input logic v, input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi);
    @(negedge clk);
    in_valid = v;
    a        = ai;
    b        = bi;
    #1;
    chk_comb(tag);
    @(posedge clk);
    if (v) begin
      m_sum_q   = ref_sum(ai, bi);
      m_carry_q = ref_carry(ai, bi);
      m_valid   = 1'b1;
      m_cnt     = (m_cnt + n_carries(ai, bi)) % (1 << CNT_W);
    end else begin
      m_valid = 1'b0;
    end
    #1;
    chk_reg(tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk_reg("rst_pulse");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] pat;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    model_reset();

    // Reset state and comb path while reset is held.
    #2;
    chk_reg("reset");
    chk_comb("reset_comb");

    // Single-lane truth table, one time unit apart.
    for (int k = 0; k < 4; k++) begin
      pat = 2'(k);
      a   = {{(WIDTH-1){1'b0}}, pat[1]};
      b   = {{(WIDTH-1){1'b0}}, pat[0]};
      #1;
      chk_comb($sformatf("tt%0d", k));
    end

    @(negedge clk);
    rst = 1'b0;

    // Registered latency and hold on invalid.
    cycle("lat_cap", 1'b1, 4'b0001, 4'b0001);
    chk("lat_carry_q_lane0", 32'(carry_q[0]), 32'd1);
    cycle("lat_hold", 1'b0, 4'b0010, 4'b0000);
    chk("lat_hold_carry_q", 32'(carry_q), 32'd1);

    // Async reset between edges with a live result.
    cycle("pre_async", 1'b1, 4'b1011, 4'b0011);
    @(negedge clk);
    #2;
    rst = 1'b1;
    a   = 4'b0110;
    b   = 4'b0101;
    #1;
    model_reset();
    chk_reg("async_rst");
    chk_comb("async_rst_comb");
    @(posedge clk);
    #1;
    chk_reg("async_rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Multi-lane pattern.
    cycle("multi", 1'b1, 4'b1100, 4'b1010);
    chk("multi_sum_q",   32'(sum_q),   32'(4'b0110));
    chk("multi_carry_q", 32'(carry_q), 32'(4'b1000));

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      cycle($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
            WIDTH'($urandom), WIDTH'($urandom));
    end

    // Counter wrap: five full-carry cycles, then idle cycles.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      cycle($sformatf("cnt%0d", k), 1'b1, 4'b1111, 4'b1111);
    end
    for (int k = 0; k < 3; k++) begin
      cycle($sformatf("cnt_idle%0d", k), 1'b0, 4'b1111, 4'b1111);
    end
`ifdef HALF_ADDER_CNT_EN
    chk("cnt_wrap", 32'(carry_cnt), 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/half_adder.md
Name: half_adder

Overview:
- Array of WIDTH independent 1-bit half adders: per lane, sum = a XOR b, carry = a AND b.
- Combinational outputs serve glue logic and unit benches.
- A one-stage registered copy with a valid flag serves pipelined datapaths.
- Leaf arithmetic cell used by the adder/subtractor family.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, 16, width of the optional carry-event counter.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- sum  output  WIDTH  combinational a XOR b.
- carry  output  WIDTH  combinational a AND b.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  sum_q/carry_q hold a result captured from a valid input.
- carry_cnt  output  CNT_W  carry-event count; present only with HALF_ADDER_CNT_EN.

Behaviour:
- Combinational path:
  - sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i], for every lane i.
  - Zero latency; independent of clk and rst.
  - Lanes do not interact; there is no carry chaining between lanes.
  - Truth table per lane (a,b -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
  - X/Z on inputs propagates per normal operator semantics; no masking.
- Registered path, latency 1 cycle:
  - On posedge clk with in_valid=1: sum_q<=a^b, carry_q<=a&b, out_valid<=1.
  - On posedge clk with in_valid=0: sum_q and carry_q hold; out_valid<=0.
- Reset:
  - rst=1 immediately forces sum_q=0, carry_q=0, out_valid=0 (and carry_cnt=0 when present), without waiting for a clock edge.
  - Holds while rst=1.
  - First capture occurs on the first posedge with rst=0 and in_valid=1.
  - Reset asserted mid-stream discards the pending registered result.
  - Combinational sum/carry are unaffected by reset.
- No handshake or backpressure: every valid input is accepted.
- No state machine.

Optional Feature:
- Macro: HALF_ADDER_CNT_EN.
- Defined:
  - carry_cnt port exists.
  - On each posedge with in_valid=1, carry_cnt increments by popcount(a & b), modulo 2^CNT_W (wraps silently).
  - Async reset clears it to 0.
- Undefined:
  - carry_cnt port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1 combinational: apply a,b = 00, 01, 10, 11, 1 time unit apart -> sum,carry = 0,0 / 1,0 / 1,0 / 0,1.
- Registered latency: rst low, in_valid=1, a=1,b=1 -> after the next posedge sum_q=0, carry_q=1, out_valid=1. Then in_valid=0 -> out_valid=0 at the following posedge, sum_q/carry_q held.
- Async reset: with out_valid=1 and carry_q=1, assert rst between clock edges -> sum_q, carry_q, out_valid read 0 before the next posedge; comb sum/carry still track a,b.
- Multi-lane WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, carry=4'b1000, no inter-lane effect.
- Counter (HALF_ADDER_CNT_EN, WIDTH=4, CNT_W=4): 5 valid cycles of a=b=4'b1111 -> carry_cnt = 20 mod 16 = 4. Repeat with in_valid=0 -> carry_cnt unchanged.
